// File: rtl/writeback_arbiter.sv
// Write-back arbiter: merges un-stallable ALU results with queued MDU results onto one register-file write port.
// Latency: ALU result -> regWrite next cycle; accepted MDU result -> regWrite two or more cycles later.
// Backpressure: mdu_ready drops when the MDU queue is full (registered count only); the ALU path is never stalled.
module writeback_arbiter #(
    parameter int WordLen   = 32,
    parameter int WordCount = 32,
    parameter int FifoDepth = 4,
    localparam int RegBits  = $clog2(WordCount),
    localparam int CntBits  = $clog2(FifoDepth) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_wb_valid,
    input  logic [RegBits-1:0]   alu_wb_rd,
    input  logic [WordLen-1:0]   alu_wb_data,
    input  logic                 mdu_valid,
    output logic                 mdu_ready,
    input  logic [RegBits-1:0]   mdu_rd,
    input  logic [WordLen-1:0]   mdu_data,
    output logic                 regWrite,
    output logic [RegBits-1:0]   writeRegister,
    output logic [WordLen-1:0]   writeData,
    output logic [WordCount-1:0] pending_mask,
    output logic [CntBits-1:0]   fifo_count,
    output logic                 order_err
);
    localparam int PtrBits = $clog2(FifoDepth);
    localparam logic [CntBits-1:0] FullCount = CntBits'(FifoDepth);

    logic [RegBits-1:0]   entryRd   [FifoDepth];
    logic [WordLen-1:0]   entryData [FifoDepth];
    logic [PtrBits-1:0]   rdPtr;
    logic [PtrBits-1:0]   wrPtr;
    logic [CntBits-1:0]   count;
    logic [WordCount-1:0] pendingMask;
    logic [PtrBits-1:0]   offs;
    logic                 aluWr;
    logic                 push;
    logic                 pop;
    logic                 orderErr;

    assign mdu_ready    = (count < FullCount);
    assign aluWr        = alu_wb_valid && (alu_wb_rd != '0);
    // R0 writes are accepted and dropped on the floor.
    assign push         = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign pop          = !aluWr && (count != '0);
    assign pending_mask = pendingMask;
    assign fifo_count   = count;
    assign order_err    = orderErr;

    // An entry is live when its distance from the head is below the occupancy.
    always_comb begin
        pendingMask = '0;
        offs        = '0;
        for (int i = 0; i < FifoDepth; i++) begin
            offs = PtrBits'(i) - rdPtr;
            if (CntBits'(offs) < count) begin
                pendingMask[entryRd[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            entryRd[wrPtr]   <= mdu_rd;
            entryData[wrPtr] <= mdu_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdPtr         <= '0;
            wrPtr         <= '0;
            count         <= '0;
            regWrite      <= 1'b0;
            writeRegister <= '0;
            writeData     <= '0;
            orderErr      <= 1'b0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + CntBits'(1);
            end else if (pop && !push) begin
                count <= count - CntBits'(1);
            end

            regWrite <= aluWr || pop;
            if (aluWr) begin
                writeRegister <= alu_wb_rd;
                writeData     <= alu_wb_data;
            end else if (pop) begin
                writeRegister <= entryRd[rdPtr];
                writeData     <= entryData[rdPtr];
            end else begin
                writeRegister <= '0;
                writeData     <= '0;
            end

            if (aluWr && pendingMask[alu_wb_rd]) begin
                orderErr <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scoreboard bench: the driver updates a queue-based model and pushes expected state/writes; a monitor compares after each edge.
module tb_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_wb_valid;
    logic [4:0]  alu_wb_rd;
    logic [31:0] alu_wb_data;
    logic        mdu_valid;
    logic        mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        regWrite;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [31:0] pending_mask;
    logic [2:0]  fifo_count;
    logic        order_err;

    writeback_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData),
        .pending_mask(pending_mask), .fifo_count(fifo_count), .order_err(order_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        bit          wr;
        int          cnt;
        logic [31:0] mask;
        bit          err;
    } stat_t;

    wr_t   modelQ[$];
    wr_t   expW[$];
    stat_t statQ[$];
    bit    modelErr;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] modelMask();
        logic [31:0] m = '0;
        foreach (modelQ[i]) m[modelQ[i].rd] = 1'b1;
        return m;
    endfunction

    function automatic stat_t snap(bit wr);
        stat_t s;
        s.wr   = wr;
        s.cnt  = modelQ.size();
        s.mask = modelMask();
        s.err  = modelErr;
        return s;
    endfunction

    // One cycle of traffic; the model computes the state after the coming edge.
    task automatic drive(input bit av, input logic [4:0] ard, input logic [31:0] ad,
                         input bit mv, input logic [4:0] mrd, input logic [31:0] md);
        bit wr;
        bit accept;
        wr_t e;
        @(negedge clk);
        rst = 1'b0;
        alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = ad;
        mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
        accept = mv && (modelQ.size() < 4);
        wr = 1'b0;
        if (av && ard != 0) begin
            if (modelMask()[ard]) modelErr = 1'b1;
            e.rd = ard; e.data = ad;
            expW.push_back(e);
            wr = 1'b1;
        end else if (modelQ.size() > 0) begin
            expW.push_back(modelQ.pop_front());
            wr = 1'b1;
        end
        if (accept && mrd != 0) begin
            e.rd = mrd; e.data = md;
            modelQ.push_back(e);
        end
        statQ.push_back(snap(wr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst = 1'b1;
            alu_wb_valid = 0; mdu_valid = 0;
            modelQ.delete();
            expW.delete();
            modelErr = 1'b0;
            statQ.push_back(snap(1'b0));
        end
    endtask

    always @(posedge clk) begin
        stat_t s;
        wr_t   e;
        #1;
        if (statQ.size() > 0) begin
            s = statQ.pop_front();
            chk("regWrite", regWrite, s.wr);
            chk("fifo_count", fifo_count, s.cnt);
            chk("mdu_ready", mdu_ready, s.cnt < 4);
            chk("pending_mask", pending_mask, s.mask);
            chk("order_err", order_err, s.err);
            if (regWrite) begin
                chk("write_nonzero_rd", writeRegister != 0, 1);
                if (expW.size() == 0) begin
                    chk("unexpected_write", 1, 0);
                end else begin
                    e = expW.pop_front();
                    chk("writeRegister", writeRegister, e.rd);
                    chk("writeData", writeData, e.data);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        modelErr = 0;

        doReset(2);
        idle(2);
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 1, 7, 32'h12);
        idle(3);
        // Fill the queue while the ALU occupies the port every cycle.
        for (int i = 1; i <= 4; i++) drive(1, 5'(20 + i), $urandom, 1, 5'(i), 32'h100 + i);
        drive(1, 25, $urandom, 1, 6, 32'hBAD);
        idle(6);
        drive(1, 0, 32'h55, 1, 0, 32'h66);
        idle(2);
        drive(0, 0, 0, 1, 9, 32'h99);
        drive(1, 9, 32'h999, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 3; i++) drive(1, 30, $urandom, 1, 5'(11 + i), $urandom);
        doReset(1);
        idle(4);

        // Randomized traffic with phases of heavy and light ALU load.
        for (int i = 0; i < 3000; i++) begin
            int aluPct;
            aluPct = ((i / 200) % 2 == 0) ? 85 : 30;
            if ($urandom_range(0, 399) == 0) begin
                doReset(1);
            end else begin
                drive($urandom_range(0, 99) < aluPct, 5'($urandom_range(0, 9)), $urandom,
                      $urandom_range(0, 99) < 60, 5'($urandom_range(0, 9)), $urandom);
            end
        end
        idle(8);
        @(negedge clk);
        chk("writes_drained", expW.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
